// File: rtl/iob_assim_mem_pkg.sv
// Shared helpers and default-geometry constants for the asymmetric tiled RAM.
// Modules derive their own geometry from their parameters using clog2_min1.
package iob_assim_mem_pkg;

  // Width of a select field; never zero so a single tile/lane still has a 1-bit select.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  localparam int unsigned DEF_DATA_W_A    = 32;
  localparam int unsigned DEF_DATA_W_B    = 8;
  localparam int unsigned DEF_N_WORDS     = 8192;
  localparam int unsigned DEF_TILE_ADDR_W = 11;

  localparam bit          R_BIG      = (DEF_DATA_W_B > DEF_DATA_W_A);
  localparam int unsigned R          = R_BIG ? DEF_DATA_W_B / DEF_DATA_W_A
                                             : DEF_DATA_W_A / DEF_DATA_W_B;
  localparam int unsigned NARROW_W   = R_BIG ? DEF_DATA_W_A : DEF_DATA_W_B;
  localparam int unsigned WIDE_W     = R_BIG ? DEF_DATA_W_B : DEF_DATA_W_A;
  localparam int unsigned N_TILES    = DEF_N_WORDS >> DEF_TILE_ADDR_W;
  localparam int unsigned TILE_SEL_W = clog2_min1(N_TILES);
  localparam int unsigned LANE_SEL_W = clog2_min1(R);

endpackage

// File: rtl/iob_2p_assim_mem_tile.sv
// One storage tile: Ratio lane RAMs of narrow width, per-lane write enables,
// shared row address, read-first synchronous read register with enable.
module iob_2p_assim_mem_tile
  import iob_assim_mem_pkg::*;
#(
  parameter int unsigned NarrowW = 8,
  parameter int unsigned Ratio   = 4,
  parameter int unsigned RowW    = 9
) (
  input  logic                       clk_i,
  input  logic [Ratio-1:0]           we_i,
  input  logic [RowW-1:0]            w_row_i,
  input  logic [Ratio*NarrowW-1:0]   w_data_i,
  input  logic                       re_i,
  input  logic [RowW-1:0]            r_row_i,
  output logic [Ratio*NarrowW-1:0]   r_data_o
);

  localparam int unsigned Depth = 2 ** RowW;

  for (genvar k = 0; k < Ratio; k++) begin : g_lane
    logic [NarrowW-1:0] mem [Depth];
    logic [NarrowW-1:0] rd_d, rd_q;

    always_comb begin
      rd_d = rd_q;
      if (re_i) rd_d = mem[r_row_i];
    end

    // Nonblocking read of mem gives old data on a same-row write (read-first).
    always_ff @(posedge clk_i) begin
      if (we_i[k]) mem[w_row_i] <= w_data_i[k*NarrowW +: NarrowW];
      rd_q <= rd_d;
    end

    assign r_data_o[k*NarrowW +: NarrowW] = rd_q;
  end

endmodule

// File: rtl/iob_2p_assim_mem_tiled_core.sv
// Two-port asymmetric-width RAM built from N_TILES tiles; top holds decode, lane routing, output mux.
// Optional macro ASSIM_MEM_WRITE_THROUGH_EN adds per-lane write-first forwarding on collisions.
module iob_2p_assim_mem_tiled_core
  import iob_assim_mem_pkg::*;
#(
  parameter int unsigned DATA_W_A    = 32,
  parameter int unsigned DATA_W_B    = 8,
  parameter int unsigned N_WORDS     = 8192,
  parameter int unsigned TILE_ADDR_W = 11,
  parameter int unsigned USE_RAM     = 0,
  localparam int unsigned WAddrW     = $clog2(N_WORDS * DATA_W_A / 8),
  localparam int unsigned RAddrW     = $clog2(N_WORDS * DATA_W_B / 8)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_en,
  input  logic [WAddrW-1:0]   w_addr,
  input  logic [DATA_W_A-1:0] data_in,
  input  logic                r_en,
  input  logic [RAddrW-1:0]   r_addr,
  output logic [DATA_W_B-1:0] data_out
);

  localparam bit          WWide    = (DATA_W_A > DATA_W_B);
  localparam bit          RWide    = (DATA_W_B > DATA_W_A);
  localparam int unsigned Ratio    = WWide ? DATA_W_A / DATA_W_B : DATA_W_B / DATA_W_A;
  localparam int unsigned NarrowW  = WWide ? DATA_W_B : DATA_W_A;
  localparam int unsigned LaneBits = $clog2(Ratio);
  localparam int unsigned LaneSelW = clog2_min1(Ratio);
  localparam int unsigned NAddrW   = $clog2(N_WORDS);
  localparam int unsigned NTiles   = N_WORDS >> TILE_ADDR_W;
  localparam int unsigned TileSelW = clog2_min1(NTiles);
  localparam int unsigned RowW     = TILE_ADDR_W - LaneBits;
  localparam int unsigned LanesW   = Ratio * NarrowW;

  logic                w_en_eff, rd_load;
  logic [NAddrW-1:0]   w_naddr, r_naddr;
  logic [TileSelW-1:0] w_tile, r_tile;
  logic [RowW-1:0]     w_row, r_row;
  logic [LaneSelW-1:0] w_lane, r_lane;
  logic [Ratio-1:0]    w_lane_en;
  logic [LanesW-1:0]   w_lanes, rd_lanes;
  logic [LanesW-1:0]   tile_rdata [NTiles];
  logic [DATA_W_B-1:0] data_sel;

  logic                r_valid_d, r_valid_q;
  logic [TileSelW-1:0] r_tile_d, r_tile_q;
  logic [LaneSelW-1:0] r_lane_d, r_lane_q;

  // Both ports are reduced to a narrow-word address; shifting out the top drops aliased bits.
  always_comb begin
    w_en_eff = w_en & rst_n;
    rd_load  = (USE_RAM != 0) ? r_en : 1'b1;
    w_naddr  = NAddrW'(w_addr) << (WWide ? LaneBits : 0);
    r_naddr  = NAddrW'(r_addr) << (RWide ? LaneBits : 0);
    w_tile   = TileSelW'(w_naddr >> TILE_ADDR_W);
    r_tile   = TileSelW'(r_naddr >> TILE_ADDR_W);
    w_row    = RowW'(w_naddr >> LaneBits);
    r_row    = RowW'(r_naddr >> LaneBits);
    w_lane   = LaneSelW'(w_naddr & NAddrW'(Ratio - 1));
    r_lane   = LaneSelW'(r_naddr & NAddrW'(Ratio - 1));
    for (int k = 0; k < Ratio; k++) begin
      w_lane_en[k] = WWide || (w_lane == LaneSelW'(k));
    end
  end

  if (WWide) begin : g_wr_wide
    assign w_lanes = data_in;
  end else begin : g_wr_narrow
    assign w_lanes = {Ratio{data_in}};
  end

  for (genvar t = 0; t < NTiles; t++) begin : g_tile
    logic [Ratio-1:0] tile_we;
    logic             tile_re;

    assign tile_we = w_lane_en & {Ratio{w_en_eff && (w_tile == TileSelW'(t))}};
    assign tile_re = rd_load && (r_tile == TileSelW'(t));

    iob_2p_assim_mem_tile #(
      .NarrowW (NarrowW),
      .Ratio   (Ratio),
      .RowW    (RowW)
    ) u_tile (
      .clk_i    (clk),
      .we_i     (tile_we),
      .w_row_i  (w_row),
      .w_data_i (w_lanes),
      .re_i     (tile_re),
      .r_row_i  (r_row),
      .r_data_o (tile_rdata[t])
    );
  end

  always_comb begin
    r_valid_d = r_valid_q | rd_load;
    r_tile_d  = rd_load ? r_tile : r_tile_q;
    r_lane_d  = rd_load ? r_lane : r_lane_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= 1'b0;
      r_tile_q  <= '0;
      r_lane_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_tile_q  <= r_tile_d;
      r_lane_q  <= r_lane_d;
    end
  end

`ifdef ASSIM_MEM_WRITE_THROUGH_EN
  logic [Ratio-1:0]  fwd_hit_d, fwd_hit_q;
  logic [LanesW-1:0] fwd_data_d, fwd_data_q;

  // Capture, per physical lane, whether this cycle's write lands on the row being read.
  always_comb begin
    fwd_hit_d  = fwd_hit_q;
    fwd_data_d = fwd_data_q;
    if (rd_load) begin
      fwd_data_d = w_lanes;
      for (int k = 0; k < Ratio; k++) begin
        fwd_hit_d[k] = w_en_eff && (w_tile == r_tile) && (w_row == r_row) && w_lane_en[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  always_comb begin
    rd_lanes = tile_rdata[r_tile_q];
    for (int k = 0; k < Ratio; k++) begin
      if (fwd_hit_q[k]) rd_lanes[k*NarrowW +: NarrowW] = fwd_data_q[k*NarrowW +: NarrowW];
    end
  end
`else
  assign rd_lanes = tile_rdata[r_tile_q];
`endif

  if (WWide) begin : g_rd_narrow
    assign data_sel = rd_lanes[r_lane_q*NarrowW +: NarrowW];
  end else begin : g_rd_wide
    assign data_sel = rd_lanes;
  end

  assign data_out = r_valid_q ? data_sel : '0;

  logic unused_sigs;
  assign unused_sigs = ^{w_addr, r_addr, r_en, r_lane_q};

endmodule

// File: tb/tb_iob_2p_assim_mem_tiled_core.sv
// Directed bench: three instances (32->8 USE_RAM=1, 8->32 USE_RAM=1, 8->8 USE_RAM=0).
module tb_iob_2p_assim_mem_tiled_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        wn_w_en, wn_r_en;
  logic [14:0] wn_w_addr;
  logic [31:0] wn_data_in;
  logic [12:0] wn_r_addr;
  logic [7:0]  wn_dout;

  logic        nw_w_en, nw_r_en;
  logic [12:0] nw_w_addr;
  logic [7:0]  nw_data_in;
  logic [14:0] nw_r_addr;
  logic [31:0] nw_dout;

  logic        eq_w_en, eq_r_en;
  logic [12:0] eq_w_addr;
  logic [7:0]  eq_data_in;
  logic [12:0] eq_r_addr;
  logic [7:0]  eq_dout;

  int n_checks = 0;
  int n_pass   = 0;

  iob_2p_assim_mem_tiled_core #(
    .DATA_W_A(32), .DATA_W_B(8), .N_WORDS(8192), .TILE_ADDR_W(11), .USE_RAM(1)
  ) u_wn (
    .clk(clk), .rst_n(rst_n), .w_en(wn_w_en), .w_addr(wn_w_addr), .data_in(wn_data_in),
    .r_en(wn_r_en), .r_addr(wn_r_addr), .data_out(wn_dout)
  );

  iob_2p_assim_mem_tiled_core #(
    .DATA_W_A(8), .DATA_W_B(32), .N_WORDS(8192), .TILE_ADDR_W(11), .USE_RAM(1)
  ) u_nw (
    .clk(clk), .rst_n(rst_n), .w_en(nw_w_en), .w_addr(nw_w_addr), .data_in(nw_data_in),
    .r_en(nw_r_en), .r_addr(nw_r_addr), .data_out(nw_dout)
  );

  iob_2p_assim_mem_tiled_core #(
    .DATA_W_A(8), .DATA_W_B(8), .N_WORDS(8192), .TILE_ADDR_W(11), .USE_RAM(0)
  ) u_eq (
    .clk(clk), .rst_n(rst_n), .w_en(eq_w_en), .w_addr(eq_w_addr), .data_in(eq_data_in),
    .r_en(eq_r_en), .r_addr(eq_r_addr), .data_out(eq_dout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eq_write(input logic [12:0] a, input logic [7:0] d);
    eq_w_en = 1'b1; eq_w_addr = a; eq_data_in = d;
    tick();
    eq_w_en = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_word;
    rst_n = 1'b0;
    wn_w_en = 0; wn_r_en = 0; wn_w_addr = '0; wn_data_in = '0; wn_r_addr = '0;
    nw_w_en = 0; nw_r_en = 0; nw_w_addr = '0; nw_data_in = '0; nw_r_addr = '0;
    eq_w_en = 0; eq_r_en = 0; eq_w_addr = '0; eq_data_in = '0; eq_r_addr = '0;
    #2;
    check_eq("rst_wn", 32'(wn_dout), 32'h0);
    check_eq("rst_nw", nw_dout, 32'h0);
    check_eq("rst_eq", 32'(eq_dout), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Wide writes of bytes 0x20..0x2F
    for (int i = 0; i < 4; i++) begin
      wn_w_en = 1'b1; wn_w_addr = 15'(i);
      wn_data_in = 32'h23222120 + 32'(i) * 32'h04040404;
      tick();
    end
    wn_w_en = 1'b0;

    // r_en low: register must not load
    for (int i = 0; i < 16; i++) begin
      wn_r_addr = 13'(i);
      tick();
      check_eq($sformatf("wn_noren_%0d", i), 32'(wn_dout), 32'h0);
    end

    wn_r_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wn_r_addr = 13'(i);
      tick();
      check_eq($sformatf("wn_rd_%0d", i), 32'(wn_dout), 32'h20 + 32'(i));
    end
    wn_r_en = 1'b0; wn_r_addr = 13'd0;
    tick();
    check_eq("wn_hold", 32'(wn_dout), 32'h2F);

    // Wide address 2049 aliases word 1 (bytes 4..7)
    wn_w_en = 1'b1; wn_w_addr = 15'd2049; wn_data_in = 32'hDDCCBBAA;
    tick();
    wn_w_en = 1'b0; wn_r_en = 1'b1; wn_r_addr = 13'd4;
    tick();
    check_eq("wn_alias_lo", 32'(wn_dout), 32'hAA);
    wn_r_addr = 13'd7;
    tick();
    check_eq("wn_alias_hi", 32'(wn_dout), 32'hDD);
    wn_r_en = 1'b0;

    // Narrow writes, wide reads
    for (int i = 0; i < 16; i++) begin
      nw_w_en = 1'b1; nw_w_addr = 13'(i); nw_data_in = 8'h20 + 8'(i);
      tick();
    end
    nw_w_en = 1'b0; nw_r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nw_r_addr = 15'(i);
      tick();
      exp_word = 32'h23222120 + 32'(i) * 32'h04040404;
      check_eq($sformatf("nw_rd_%0d", i), nw_dout, exp_word);
    end
    nw_r_addr = 15'd2049;
    tick();
    check_eq("nw_alias", nw_dout, 32'h27262524);
    nw_r_en = 1'b0;

    // Tile boundaries; USE_RAM=0 so r_en stays low
    eq_write(13'd2047, 8'hAA);
    eq_write(13'd2048, 8'h55);
    eq_write(13'd8191, 8'h11);
    eq_r_addr = 13'd2047; tick(); check_eq("eq_2047", 32'(eq_dout), 32'hAA);
    eq_r_addr = 13'd2048; tick(); check_eq("eq_2048", 32'(eq_dout), 32'h55);
    eq_r_addr = 13'd8191; tick(); check_eq("eq_8191", 32'(eq_dout), 32'h11);

    // Collision
    eq_write(13'd10, 8'h20);
    eq_w_en = 1'b1; eq_w_addr = 13'd10; eq_data_in = 8'h77; eq_r_addr = 13'd10;
    tick();
    eq_w_en = 1'b0;
`ifdef ASSIM_MEM_WRITE_THROUGH_EN
    check_eq("eq_collide", 32'(eq_dout), 32'h77);
`else
    check_eq("eq_collide", 32'(eq_dout), 32'h20);
`endif
    tick();
    check_eq("eq_after", 32'(eq_dout), 32'h77);

    // Reset mid-stream
    wn_r_en = 1'b1; wn_r_addr = 13'd3;
    tick();
    check_eq("wn_pre_rst", 32'(wn_dout), 32'h23);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("wn_async_rst", 32'(wn_dout), 32'h0);
    wn_r_en = 1'b0;
    wn_w_en = 1'b1; wn_w_addr = 15'd0; wn_data_in = 32'hFFFFFFFF;
    tick(); tick();
    wn_w_en = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("wn_post_rst_idle", 32'(wn_dout), 32'h0);
    wn_r_en = 1'b1; wn_r_addr = 13'd3;
    tick();
    check_eq("wn_kept_3", 32'(wn_dout), 32'h23);
    wn_r_addr = 13'd0;
    tick();
    check_eq("wn_kept_0", 32'(wn_dout), 32'h20);
    wn_r_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
